rvfi_shadow_checker: RTL and testbench
======================================

Name: rvfi_shadow_checker

Overview:
- Sequential successor to the single-instruction semantics harness: checks a continuous RVFI retirement stream rather than one instruction in isolation.
- Keeps a shadow register file, PC and order counter, and checks every retirement against them:
  - rs1/rs2 read data;
  - PC continuity;
  - order continuity;
  - x0 invariance;
  - lane contiguity.
- Sits beside the core (or an insn-model harness) in formal and simulation benches. Parametrised in XLEN, register count and retire width NRET.

Parameters:
- XLEN, 32, data/PC width (32 or 64).
- NREGS, 32, architectural register count (32 for RV32I, 16 for RV32E); register addresses >= NREGS raise code 7.
- NRET, 1, retirement lanes per cycle (1..4).
- STICKY, 1, 1 = freeze first error until reset; 0 = report every error.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rvfi_valid  in  NRET  per-lane retirement valid.
- rvfi_order  in  64*NRET  per-lane retirement index.
- rvfi_trap  in  NRET  per-lane trap flag.
- rvfi_pc_rdata  in  XLEN*NRET  PC of the retired instruction.
- rvfi_pc_wdata  in  XLEN*NRET  next PC.
- rvfi_rs1_addr, rvfi_rs2_addr  in  5*NRET  source register addresses.
- rvfi_rs1_rdata, rvfi_rs2_rdata  in  XLEN*NRET  source read data.
- rvfi_rd_addr  in  5*NRET  destination register address.
- rvfi_rd_wdata  in  XLEN*NRET  destination write data.
- err_valid  out  1  pulse (STICKY=0) or level (STICKY=1) when an error is reported.
- err_code  out  3  error code (see Behaviour).
- err_lane  out  2  lane that caused the error.
- err_order  out  64  rvfi_order of the offending retirement.
- error  out  1  sticky OR of all errors since reset.
- retired  out  32  count of valid retirements, wrapping.

Behaviour:
- Reset (async, reset=0):
  - all shadow-valid bits, pc_known and order_known cleared;
  - all outputs 0.
  - Takes effect mid-stream: any retirement presented during reset is ignored.
- Shadow state per register r (1..NREGS-1): value[XLEN] plus known bit. x0 is always known and always 0.
- Lanes are processed in ascending order within a cycle. Lane i sees the shadow state after lanes 0..i-1 of the same cycle have been applied (combinational forwarding). The committed state updates at the clock edge.
- Per valid lane, checks are evaluated in code order:
  - Code 1, rs1: if rs1 is known and rs1_rdata != value -> error. If unknown: adopt rs1_rdata, set known, no error.
  - Code 2, rs2: same rule as rs1. If rs1_addr == rs2_addr and the register is unknown, adopt rs1_rdata; a differing rs2_rdata then raises code 2.
  - Code 3, PC: if pc_known and pc_rdata != predicted_pc -> error.
  - Code 4, order: if order_known and order != last_order+1 -> error.
  - Code 5, x0: a read of x0 returning nonzero -> error. rd=x0 writes are discarded silently.
  - Code 6, lane contiguity: if rvfi_valid[i]=1 while rvfi_valid[j]=0 for some j<i -> error, reported on lane i; that lane is still processed.
  - Code 7: rs1, rs2 or rd address >= NREGS -> error. The bad operand is skipped.
- Updates per valid lane:
  - Non-trap: rd != 0 -> value = rd_wdata, known = 1. Then predicted_pc = pc_wdata and pc_known = 1.
  - Trap: no rd update; pc_known cleared, since the next PC belongs to the handler.
  - Always: last_order = order, order_known = 1, retired += 1.
- Reporting latency: 1 cycle. Errors from a retirement cycle appear on err_* at the next rising edge.
- Multiple errors in one cycle: lowest lane wins; within a lane, lowest code wins.
- STICKY=1: the first error is captured; err_valid stays 1 and err_code, err_lane and err_order hold until reset. Later errors update only error, which is already 1.
- STICKY=0: err_valid is a one-cycle pulse per erroring cycle.
- Shadow state keeps updating after an error in both modes.
- Wrap-around:
  - retired wraps 2^32-1 -> 0 without error.
  - An order of 2^64-1 followed by 0 is legal.

Test Plan:
- Reset, then one retirement reading x5=0x1234 (unknown) -> no error, x5 learned. Next retirement reads x5=0x1235 -> err_valid=1, err_code=1, err_lane=0 one cycle later.
- NRET=2, one cycle: lane0 writes x3=0xDEADBEEF, lane1 reads rs1=x3 with 0xDEADBEEF -> no error (forwarding). Lane1 reading 0xDEADBEEE instead -> code 1, lane 1.
- Retire pc_rdata=0x100 with pc_wdata=0x104, then pc_rdata=0x108 -> code 3. After a trap retirement, any next pc_rdata -> no error.
- Orders 7 then 9 -> code 4, err_order=9. Orders 2^64-1 then 0 -> no error.
- NRET=2, rvfi_valid=2'b10 -> code 6, lane 1. NREGS=16, rd=x17 -> code 7. Read of x0 returning 5 -> code 5.
- STICKY=1: code 1 then later code 3 -> err_code stays 1. Then assert reset for 1 cycle -> all outputs 0, shadow cleared, and a read of x5=0x9999 -> no error.

Source files
------------

// File: rtl/rvfi_shadow_checker.sv
// rvfi_shadow_checker: shadow regfile/PC/order checker for a multi-lane RVFI retirement stream
module rvfi_shadow_checker #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRET   = 1,
    parameter int STICKY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
    input  logic [5*NRET-1:0]    rvfi_rs1_addr,
    input  logic [5*NRET-1:0]    rvfi_rs2_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
    input  logic [5*NRET-1:0]    rvfi_rd_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rd_wdata,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [1:0]           err_lane,
    output logic [63:0]          err_order,
    output logic                 error,
    output logic [31:0]          retired
);
    logic [XLEN-1:0] rf_val [32];
    logic [XLEN-1:0] rf_val_n [32];
    logic [31:0]     rf_known, rf_known_n;
    logic [XLEN-1:0] pred_pc, pred_pc_n;
    logic            pc_known, pc_known_n;
    logic [63:0]     last_order, last_order_n;
    logic            order_known, order_known_n;
    logic [31:0]     retired_n;
    logic            hit;
    logic [2:0]      hit_code;
    logic [1:0]      hit_lane;
    logic [63:0]     hit_order;

    // walk lanes in order, forwarding shadow state lane to lane and picking the first error
    always_comb begin
        rf_val_n      = rf_val;
        rf_known_n    = rf_known;
        pred_pc_n     = pred_pc;
        pc_known_n    = pc_known;
        last_order_n  = last_order;
        order_known_n = order_known;
        retired_n     = retired;
        hit           = 1'b0;
        hit_code      = 3'd0;
        hit_lane      = 2'd0;
        hit_order     = 64'd0;
        for (int i = 0; i < NRET; i++) begin
            logic [4:0]      a1, a2, ad;
            logic [XLEN-1:0] d1, d2;
            logic [63:0]     ord;
            logic            b1, b2, bd, gap, e1, e2, e3, e4, e5;
            logic [2:0]      c;
            a1  = rvfi_rs1_addr[5*i +: 5];
            a2  = rvfi_rs2_addr[5*i +: 5];
            ad  = rvfi_rd_addr[5*i +: 5];
            d1  = rvfi_rs1_rdata[XLEN*i +: XLEN];
            d2  = rvfi_rs2_rdata[XLEN*i +: XLEN];
            ord = rvfi_order[64*i +: 64];
            b1  = 32'(a1) >= 32'(NREGS);
            b2  = 32'(a2) >= 32'(NREGS);
            bd  = 32'(ad) >= 32'(NREGS);
            gap = 1'b0;
            for (int j = 0; j < i; j++) gap = gap | !rvfi_valid[j];
            e1  = 1'b0;
            e2  = 1'b0;
            e3  = 1'b0;
            e4  = 1'b0;
            e5  = 1'b0;
            c   = 3'd0;
            if (rvfi_valid[i]) begin
                if (!b1 && a1 != 5'd0) begin
                    if (rf_known_n[a1]) e1 = d1 != rf_val_n[a1];
                    else begin
                        rf_val_n[a1]   = d1;
                        rf_known_n[a1] = 1'b1;
                    end
                end
                if (!b2 && a2 != 5'd0) begin
                    if (rf_known_n[a2]) e2 = d2 != rf_val_n[a2];
                    else begin
                        rf_val_n[a2]   = d2;
                        rf_known_n[a2] = 1'b1;
                    end
                end
                e3 = pc_known_n && rvfi_pc_rdata[XLEN*i +: XLEN] != pred_pc_n;
                e4 = order_known_n && ord != last_order_n + 64'd1;
                e5 = (a1 == 5'd0 && d1 != '0) || (a2 == 5'd0 && d2 != '0);
                c  = e1 ? 3'd1 : e2 ? 3'd2 : e3 ? 3'd3 : e4 ? 3'd4 : e5 ? 3'd5 :
                     gap ? 3'd6 : (b1 || b2 || bd) ? 3'd7 : 3'd0;
                if (c != 3'd0 && !hit) begin
                    hit       = 1'b1;
                    hit_code  = c;
                    hit_lane  = 2'(i);
                    hit_order = ord;
                end
                if (!rvfi_trap[i]) begin
                    if (!bd && ad != 5'd0) begin
                        rf_val_n[ad]   = rvfi_rd_wdata[XLEN*i +: XLEN];
                        rf_known_n[ad] = 1'b1;
                    end
                    pred_pc_n  = rvfi_pc_wdata[XLEN*i +: XLEN];
                    pc_known_n = 1'b1;
                end else begin
                    pc_known_n = 1'b0;
                end
                last_order_n  = ord;
                order_known_n = 1'b1;
                retired_n     = retired_n + 32'd1;
            end
        end
    end

    // register values need no reset: their known bits gate every use
    always_ff @(posedge clock) begin
        rf_val <= rf_val_n;
    end

    // commit shadow state and report the winning error one cycle after retirement
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rf_known    <= '0;
            pred_pc     <= '0;
            pc_known    <= 1'b0;
            last_order  <= '0;
            order_known <= 1'b0;
            retired     <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            err_lane    <= '0;
            err_order   <= '0;
            error       <= 1'b0;
        end else begin
            rf_known    <= rf_known_n;
            pred_pc     <= pred_pc_n;
            pc_known    <= pc_known_n;
            last_order  <= last_order_n;
            order_known <= order_known_n;
            retired     <= retired_n;
            error       <= error | hit;
            if (STICKY != 0 ? hit && !err_valid : hit) begin
                err_code  <= hit_code;
                err_lane  <= hit_lane;
                err_order <= hit_order;
            end
            err_valid <= STICKY != 0 ? err_valid | hit : hit;
        end
    end
endmodule

// File: tb/tb_rvfi_shadow_checker.sv
// tb_rvfi_shadow_checker: scoreboard bench driving a pulse-mode and a sticky-mode checker in parallel
module tb_rvfi_shadow_checker;
    localparam int XLEN = 32, NREGS = 16, NRET = 2;

    typedef struct packed {
        logic        v;
        logic [2:0]  c;
        logic [1:0]  l;
        logic [63:0] o;
    } exp_t;

    logic                 clock = 1'b0, reset = 1'b0;
    logic [NRET-1:0]      valid, trap;
    logic [64*NRET-1:0]   order;
    logic [XLEN*NRET-1:0] pcr, pcw, d1, d2, wd;
    logic [5*NRET-1:0]    a1, a2, ad;
    logic                 p_ev, p_err, s_ev, s_err;
    logic [2:0]           p_code, s_code;
    logic [1:0]           p_lane, s_lane;
    logic [63:0]          p_ord, s_ord;
    logic [31:0]          p_ret, s_ret;

    exp_t        q[$];
    exp_t        sm;
    logic        em;
    logic [31:0] exp_ret;
    logic [63:0] nord, o, o0;
    logic [31:0] npc;
    int          checks = 0, failures = 0;

    always #5 clock = ~clock;

    rvfi_shadow_checker #(.XLEN(XLEN), .NREGS(NREGS), .NRET(NRET), .STICKY(0)) u_pulse (
        .clock(clock), .reset(reset), .rvfi_valid(valid), .rvfi_order(order), .rvfi_trap(trap),
        .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw), .rvfi_rs1_addr(a1), .rvfi_rs2_addr(a2),
        .rvfi_rs1_rdata(d1), .rvfi_rs2_rdata(d2), .rvfi_rd_addr(ad), .rvfi_rd_wdata(wd),
        .err_valid(p_ev), .err_code(p_code), .err_lane(p_lane), .err_order(p_ord),
        .error(p_err), .retired(p_ret)
    );

    rvfi_shadow_checker #(.XLEN(XLEN), .NREGS(NREGS), .NRET(NRET), .STICKY(1)) u_sticky (
        .clock(clock), .reset(reset), .rvfi_valid(valid), .rvfi_order(order), .rvfi_trap(trap),
        .rvfi_pc_rdata(pcr), .rvfi_pc_wdata(pcw), .rvfi_rs1_addr(a1), .rvfi_rs2_addr(a2),
        .rvfi_rs1_rdata(d1), .rvfi_rs2_rdata(d2), .rvfi_rd_addr(ad), .rvfi_rd_wdata(wd),
        .err_valid(s_ev), .err_code(s_code), .err_lane(s_lane), .err_order(s_ord),
        .error(s_err), .retired(s_ret)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear();
        valid = '0; trap = '0; order = '0; pcr = '0; pcw = '0;
        a1 = '0; a2 = '0; ad = '0; d1 = '0; d2 = '0; wd = '0;
    endtask

    task automatic lane(input int l, input logic [4:0] r1, input logic [31:0] v1,
                        input logic [4:0] r2, input logic [31:0] v2,
                        input logic [4:0] rd, input logic [31:0] w);
        valid[l] = 1'b1;
        trap[l] = 1'b0;
        order[64*l +: 64] = nord;
        nord = nord + 64'd1;
        pcr[32*l +: 32] = npc;
        pcw[32*l +: 32] = npc + 32'd4;
        npc = npc + 32'd4;
        a1[5*l +: 5] = r1; d1[32*l +: 32] = v1;
        a2[5*l +: 5] = r2; d2[32*l +: 32] = v2;
        ad[5*l +: 5] = rd; wd[32*l +: 32] = w;
    endtask

    task automatic step(input logic v, input logic [2:0] c, input logic [1:0] l, input logic [63:0] ord);
        exp_t e;
        q.push_back('{v: v, c: c, l: l, o: ord});
        exp_ret = exp_ret + 32'($countones(valid));
        @(posedge clock);
        #1;
        e = q.pop_front();
        if (e.v && !sm.v) sm = e;
        em = em | e.v;
        chk("pulse_valid", {63'd0, p_ev}, {63'd0, e.v});
        if (e.v) begin
            chk("pulse_code", {61'd0, p_code}, {61'd0, e.c});
            chk("pulse_lane", {62'd0, p_lane}, {62'd0, e.l});
            chk("pulse_order", p_ord, e.o);
        end
        chk("sticky_valid", {63'd0, s_ev}, {63'd0, sm.v});
        chk("sticky_code", {61'd0, s_code}, {61'd0, sm.c});
        chk("sticky_lane", {62'd0, s_lane}, {62'd0, sm.l});
        chk("sticky_order", s_ord, sm.o);
        chk("error", {62'd0, p_err, s_err}, {62'd0, em, em});
        chk("retired", {p_ret, s_ret}, {exp_ret, exp_ret});
        clear();
    endtask

    task automatic do_reset();
        clear();
        lane(0, 5'd5, 32'hAAAA, 5'd0, 32'd0, 5'd7, 32'h77);
        reset = 1'b0;
        #1;
        chk("rst_outs", {p_ev, p_code, p_lane, p_ord, p_err, p_ret},
            {1'b0, 3'd0, 2'd0, 64'd0, 1'b0, 32'd0});
        chk("rst_outs_s", {s_ev, s_code, s_lane, s_ord, s_err, s_ret},
            {1'b0, 3'd0, 2'd0, 64'd0, 1'b0, 32'd0});
        @(posedge clock);
        #1;
        clear();
        reset = 1'b1;
        sm = '0; em = 1'b0; exp_ret = '0;
    endtask

    initial begin
        nord = 64'd100; npc = 32'h1000;
        do_reset();
        // learn x5, then mismatch it; later PC error must not disturb sticky capture
        lane(0, 5'd5, 32'h1234, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        o = nord; lane(0, 5'd5, 32'h1235, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd1, 2'd0, o);
        npc = npc + 32'd8;
        o = nord; lane(0, 5'd5, 32'h1234, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd3, 2'd0, o);
        do_reset();
        lane(0, 5'd5, 32'h9999, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        lane(0, 5'd7, 32'h1, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        // same-cycle forwarding from lane 0 to lane 1
        do_reset();
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'hDEADBEEF);
        lane(1, 5'd3, 32'hDEADBEEF, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'hDEADBEEF);
        o = nord; lane(1, 5'd3, 32'hDEADBEEE, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd1, 2'd1, o);
        // PC continuity and trap
        do_reset();
        npc = 32'h100;
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        npc = 32'h108;
        o = nord; lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd3, 2'd0, o);
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 32'h44); trap[0] = 1'b1; step(1'b0, 3'd0, 2'd0, 64'd0);
        npc = 32'h500;
        lane(0, 5'd4, 32'h55, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        // order continuity and wrap
        do_reset();
        nord = 64'd7;
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        nord = 64'd9;
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd4, 2'd0, 64'd9);
        nord = '1;
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd4, 2'd0, '1);
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        // lane gap, bad register, x0 read
        do_reset();
        o = nord; lane(1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd6, 2'd1, o);
        o = nord; lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd17, 32'd5); step(1'b1, 3'd7, 2'd0, o);
        o = nord; lane(0, 5'd0, 32'd5, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd5, 2'd0, o);
        // priorities: lowest lane, then lowest code; rs1==rs2 adoption
        do_reset();
        lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd6, 32'h10); step(1'b0, 3'd0, 2'd0, 64'd0);
        npc = npc + 32'd4;
        o0 = nord; lane(0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        lane(1, 5'd6, 32'h11, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd3, 2'd0, o0);
        nord = nord + 64'd1;
        o = nord; lane(0, 5'd6, 32'h12, 5'd0, 32'd0, 5'd0, 32'd0); step(1'b1, 3'd1, 2'd0, o);
        o = nord; lane(0, 5'd9, 32'h1, 5'd9, 32'h2, 5'd0, 32'd0); step(1'b1, 3'd2, 2'd0, o);
        lane(0, 5'd9, 32'h1, 5'd9, 32'h1, 5'd0, 32'd0); step(1'b0, 3'd0, 2'd0, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
